control_unit: RTL and testbench
===============================

# control_unit

Hardwired Moore sequencer for the Mini SRC CPU. It drives every control input of `datapath` in place of hand-stepped bench sequences. Each instruction runs the common fetch (T0–T2), then an opcode-specific execute sequence (T3–T7), then returns to T0. It sits beside `datapath`, reads the IR contents and the CON flip-flop, and stops in HALT on `halt`.

## Interface
- No parameters. Opcode encodings are fixed in `control_pkg`.
- `clk`  in  1  rising-edge clock, same clock as `datapath`
- `clr`  in  1  asynchronous, active-high reset
- `ir`  in  32  instruction register contents; opcode = `ir[31:27]`
- `con_ff`  in  1  branch condition from the CON FF logic
- `PCout`, `Zlowout`, `ZHighout`, `MDRout`, `HIout`, `LOout`, `InPortout`, `Cout`, `BAout`, `Rout`  out  1 each  bus-drive enables
- `MARin`, `PCin`, `MDRin`, `IRin`, `Yin`, `HIin`, `LOin`, `ZHIin`, `ZLOin`, `CONin`, `OutPortin`, `Rin`  out  1 each  register load enables
- `Gra`, `Grb`, `Grc`  out  1 each  register-field selects for the select/encode logic
- `IncPC`, `Read`, `Write`  out  1 each  ALU PC+1 select, memory read, memory write
- `alu_op`  out  5  equals `ir[31:27]`; consumed only while `ZLOin`/`ZHIin` is high
- `run`  out  1  high unless in HALT

## Operation
- Decided: one clock; reset is asynchronous and active-high (`clk`, `clr`).
- While `clr` is high:
  - state is IDLE, all outputs are 0, `run` is 1, `alu_op` is `ir[31:27]`.
  - Outputs are gated combinationally by `clr`, so asserting `clr` mid-instruction aborts it with no further register or memory write.
- IDLE → T0 on the first edge after `clr` falls.
- Outputs are a pure function of state (plus `ir`/`con_ff` where noted). Every non-listed signal is 0.
- Fetch:
  - T0: PCout MARin IncPC ZLOin
  - T1: Zlowout PCin Read MDRin
  - T2: MDRout IRin
- Execute (after the last listed step → T0):
  - add/sub/and/or/shr/shra/shl/ror/rol: T3 Grb Rout Yin; T4 Grc Rout ZLOin; T5 Zlowout Gra Rin
  - addi/andi/ori: T3 Grb Rout Yin; T4 Cout ZLOin; T5 Zlowout Gra Rin
  - neg/not: T3 Grb Rout ZLOin; T4 Zlowout Gra Rin
  - mul/div: T3 Gra Rout Yin; T4 Grb Rout ZHIin ZLOin; T5 Zlowout LOin; T6 ZHighout HIin
  - ldi: T3 Grb BAout Yin; T4 Cout ZLOin; T5 Zlowout Gra Rin
  - ld: ldi T3–T4; T5 Zlowout MARin; T6 Read MDRin; T7 MDRout Gra Rin
  - st: ldi T3–T4; T5 Zlowout MARin; T6 Gra Rout MDRin; T7 Write
  - br: T3 Gra Rout CONin; T4 PCout Yin; T5 Cout ZLOin; T6 Zlowout PCin only if `con_ff`=1, else T6 all-zero
  - jr: T3 Gra Rout PCin
  - jal: T3 PCout Grb Rin (link into Rb); T4 Gra Rout PCin
  - in: T3 InPortout Gra Rin. out: T3 Gra Rout OutPortin
  - mfhi: T3 HIout Gra Rin. mflo: T3 LOout Gra Rin
  - nop and undefined opcodes 11100–11111: return to T0 from T2
  - halt: T2 → HALT. HALT holds all outputs 0 and `run`=0 until `clr`.
- Opcodes: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 00101, or 00110, ror 00111, rol 01000, shr 01001, shra 01010, shl 01011, addi 01100, andi 01101, ori 01110, div 01111, mul 10000, neg 10001, not 10010, br 10011, jr 10100, jal 10101, in 10110, out 10111, mfhi 11000, mflo 11001, nop 11010, halt 11011.

## Timing
- One state per clock; state register updates on the rising `clk` edge. Outputs are valid from shortly after that edge until the next one.
- Cycles per instruction, including fetch:
  - 4: jr/in/out/mfhi/mflo
  - 5: jal, neg/not
  - 6: R-type ALU, imm, ldi
  - 7: mul/div, br (taken or not)
  - 8: ld/st
  - 3: nop
- Memory is synchronous-read within the cycle: data for `Read` in step N is captured by `MDRin` in the same step.
- `con_ff` is sampled during T6 of br only. It is valid because CONin loaded at T3.
- The opcode is sampled from `ir` at the T2→T3 transition and latched internally. `alu_op` is combinational from `ir`, which is stable after T2.

## Structure
- `control_pkg`: opcode localparams, `state_t` enum (IDLE, T0–T7, HALT), opcode-class enum.
- Sub-module `op_class_decode`: combinational 5-bit opcode → class (ALU3, ALUI, UNARY, MULDIV, LD, LDI, ST, BR, JR, JAL, IN, OUT, MFHI, MFLO, NOP, HALT).
- Top: state register + next-state logic + one output case on (state, class).

## Test plan
- Reset: hold `clr`=1 3 cycles at state T4 of mul → all outputs 0, `run`=1; release → T0 asserts PCout MARin IncPC ZLOin.
- `ir`=0x1A2B8000 (add R4,R5,R7) → T3 Grb Rout Yin, T4 Grc Rout ZLOin with `alu_op`=00011, T5 Zlowout Gra Rin, then T0 on cycle 7.
- br with `con_ff`=0 vs 1 → T6 PCin=0 vs Zlowout PCin=1; both return to T0 after T6.
- jal R8,R15 (`ir`=0xAC780000) → T3 PCout Grb Rin; T4 Gra Rout PCin; 5 cycles total.
- st (`ir`=0x10800057) → T6 Gra Rout MDRin, T7 Write=1 exactly one cycle, Read=0 throughout execute.
- halt (`ir`=0xD8000000) → HALT after T2, `run`=0, outputs frozen at 0 for 20 cycles; `clr` pulse → IDLE, `run`=1.

Source files
------------

// File: rtl/control_pkg.sv
// Shared definitions for the Mini SRC hardwired control unit:
// opcode encodings, sequencer states, opcode classes and the control word.
package control_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_JAL  = 5'b10101;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        CL_ALU3, CL_ALUI, CL_UNARY, CL_MULDIV, CL_LD, CL_LDI, CL_ST, CL_BR,
        CL_JR, CL_JAL, CL_IN, CL_OUT, CL_MFHI, CL_MFLO, CL_NOP, CL_HALT
    } op_class_t;

    // One bit per datapath control input.
    typedef struct packed {
        logic pc_out;
        logic zlo_out;
        logic zhi_out;
        logic mdr_out;
        logic hi_out;
        logic lo_out;
        logic inport_out;
        logic c_out;
        logic ba_out;
        logic r_out;
        logic mar_in;
        logic pc_in;
        logic mdr_in;
        logic ir_in;
        logic y_in;
        logic hi_in;
        logic lo_in;
        logic zhi_in;
        logic zlo_in;
        logic con_in;
        logic outport_in;
        logic r_in;
        logic gra;
        logic grb;
        logic grc;
        logic inc_pc;
        logic read;
        logic write;
    } ctrl_t;

    // Final execute state of each class; after it the sequencer returns to T0.
    // NOP and HALT never enter execute, so their entry is T2.
    function automatic state_t last_exec_state(input op_class_t cls);
        state_t s;
        case (cls)
            CL_ALU3, CL_ALUI, CL_LDI:           s = S_T5;
            CL_UNARY, CL_JAL:                   s = S_T4;
            CL_MULDIV, CL_BR:                   s = S_T6;
            CL_LD, CL_ST:                       s = S_T7;
            CL_JR, CL_IN, CL_OUT, CL_MFHI,
            CL_MFLO:                            s = S_T3;
            default:                            s = S_T2;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/control_unit_op_class_decode.sv
// Combinational opcode-to-class decoder; undefined opcodes behave as NOP.
module op_class_decode
    import control_pkg::*;
(
    input  logic [4:0] i_opcode,
    output op_class_t  o_class
);

    // Map each 5-bit opcode onto the execute sequence it shares.
    always_comb begin
        o_class = CL_NOP;
        case (i_opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL,
            OP_SHR, OP_SHRA, OP_SHL:        o_class = CL_ALU3;
            OP_ADDI, OP_ANDI, OP_ORI:       o_class = CL_ALUI;
            OP_NEG, OP_NOT:                 o_class = CL_UNARY;
            OP_MUL, OP_DIV:                 o_class = CL_MULDIV;
            OP_LD:                          o_class = CL_LD;
            OP_LDI:                         o_class = CL_LDI;
            OP_ST:                          o_class = CL_ST;
            OP_BR:                          o_class = CL_BR;
            OP_JR:                          o_class = CL_JR;
            OP_JAL:                         o_class = CL_JAL;
            OP_IN:                          o_class = CL_IN;
            OP_OUT:                         o_class = CL_OUT;
            OP_MFHI:                        o_class = CL_MFHI;
            OP_MFLO:                        o_class = CL_MFLO;
            OP_NOP:                         o_class = CL_NOP;
            OP_HALT:                        o_class = CL_HALT;
            default:                        o_class = CL_NOP;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore sequencer for the Mini SRC CPU: fetch T0-T2, class-specific
// execute T3-T7, back to T0; parks in HALT until clr.
module control_unit
    import control_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] ir,
    input  logic        con_ff,
    output logic        PCout,
    output logic        Zlowout,
    output logic        ZHighout,
    output logic        MDRout,
    output logic        HIout,
    output logic        LOout,
    output logic        InPortout,
    output logic        Cout,
    output logic        BAout,
    output logic        Rout,
    output logic        MARin,
    output logic        PCin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        HIin,
    output logic        LOin,
    output logic        ZHIin,
    output logic        ZLOin,
    output logic        CONin,
    output logic        OutPortin,
    output logic        Rin,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        IncPC,
    output logic        Read,
    output logic        Write,
    output logic [4:0]  alu_op,
    output logic        run
);

    state_t    r_state;
    state_t    w_state_next;
    state_t    w_last;
    op_class_t r_class;
    op_class_t w_class;
    ctrl_t     w_ctrl;
    ctrl_t     w_ctrl_gated;
    logic      w_unused_ir;

    op_class_decode u_decode (
        .i_opcode (ir[31:27]),
        .o_class  (w_class)
    );

    // State register; the opcode class is captured on the T2->T3 edge so
    // the execute sequence does not depend on ir after fetch.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= S_IDLE;
            r_class <= CL_NOP;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_T2) begin
                r_class <= w_class;
            end
        end
    end

    // Next-state: linear walk through the steps, leaving execute after the
    // class's final step.
    always_comb begin
        w_last       = last_exec_state(r_class);
        w_state_next = S_IDLE;
        case (r_state)
            S_IDLE: w_state_next = S_T0;
            S_T0:   w_state_next = S_T1;
            S_T1:   w_state_next = S_T2;
            S_T2: begin
                if (w_class == CL_HALT)     w_state_next = S_HALT;
                else if (w_class == CL_NOP) w_state_next = S_T0;
                else                        w_state_next = S_T3;
            end
            S_T3, S_T4, S_T5, S_T6, S_T7: begin
                if (r_state == w_last || r_state == S_T7) w_state_next = S_T0;
                else w_state_next = state_t'(r_state + 4'd1);
            end
            S_HALT: w_state_next = S_HALT;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Control word for the current (state, class); everything unlisted is 0.
    always_comb begin
        w_ctrl = '0;
        case (r_state)
            S_T0: begin w_ctrl.pc_out = 1'b1; w_ctrl.mar_in = 1'b1; w_ctrl.inc_pc = 1'b1; w_ctrl.zlo_in = 1'b1; end
            S_T1: begin w_ctrl.zlo_out = 1'b1; w_ctrl.pc_in = 1'b1; w_ctrl.read = 1'b1; w_ctrl.mdr_in = 1'b1; end
            S_T2: begin w_ctrl.mdr_out = 1'b1; w_ctrl.ir_in = 1'b1; end
            S_T3, S_T4, S_T5, S_T6, S_T7: begin
                case (r_class)
                    CL_ALU3, CL_ALUI: begin
                        case (r_state)
                            S_T3: begin w_ctrl.grb = 1'b1; w_ctrl.r_out = 1'b1; w_ctrl.y_in = 1'b1; end
                            S_T4: begin
                                w_ctrl.zlo_in = 1'b1;
                                if (r_class == CL_ALU3) begin w_ctrl.grc = 1'b1; w_ctrl.r_out = 1'b1; end
                                else                     w_ctrl.c_out = 1'b1;
                            end
                            S_T5: begin w_ctrl.zlo_out = 1'b1; w_ctrl.gra = 1'b1; w_ctrl.r_in = 1'b1; end
                            default: ;
                        endcase
                    end
                    CL_UNARY: begin
                        case (r_state)
                            S_T3: begin w_ctrl.grb = 1'b1; w_ctrl.r_out = 1'b1; w_ctrl.zlo_in = 1'b1; end
                            S_T4: begin w_ctrl.zlo_out = 1'b1; w_ctrl.gra = 1'b1; w_ctrl.r_in = 1'b1; end
                            default: ;
                        endcase
                    end
                    CL_MULDIV: begin
                        case (r_state)
                            S_T3: begin w_ctrl.gra = 1'b1; w_ctrl.r_out = 1'b1; w_ctrl.y_in = 1'b1; end
                            S_T4: begin w_ctrl.grb = 1'b1; w_ctrl.r_out = 1'b1; w_ctrl.zhi_in = 1'b1; w_ctrl.zlo_in = 1'b1; end
                            S_T5: begin w_ctrl.zlo_out = 1'b1; w_ctrl.lo_in = 1'b1; end
                            S_T6: begin w_ctrl.zhi_out = 1'b1; w_ctrl.hi_in = 1'b1; end
                            default: ;
                        endcase
                    end
                    // ldi, ld and st share the effective-address computation.
                    CL_LDI, CL_LD, CL_ST: begin
                        case (r_state)
                            S_T3: begin w_ctrl.grb = 1'b1; w_ctrl.ba_out = 1'b1; w_ctrl.y_in = 1'b1; end
                            S_T4: begin w_ctrl.c_out = 1'b1; w_ctrl.zlo_in = 1'b1; end
                            S_T5: begin
                                w_ctrl.zlo_out = 1'b1;
                                if (r_class == CL_LDI) begin w_ctrl.gra = 1'b1; w_ctrl.r_in = 1'b1; end
                                else                    w_ctrl.mar_in = 1'b1;
                            end
                            S_T6: begin
                                w_ctrl.mdr_in = 1'b1;
                                if (r_class == CL_LD) w_ctrl.read = 1'b1;
                                else begin w_ctrl.gra = 1'b1; w_ctrl.r_out = 1'b1; end
                            end
                            S_T7: begin
                                if (r_class == CL_LD) begin w_ctrl.mdr_out = 1'b1; w_ctrl.gra = 1'b1; w_ctrl.r_in = 1'b1; end
                                else                   w_ctrl.write = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    CL_BR: begin
                        case (r_state)
                            S_T3: begin w_ctrl.gra = 1'b1; w_ctrl.r_out = 1'b1; w_ctrl.con_in = 1'b1; end
                            S_T4: begin w_ctrl.pc_out = 1'b1; w_ctrl.y_in = 1'b1; end
                            S_T5: begin w_ctrl.c_out = 1'b1; w_ctrl.zlo_in = 1'b1; end
                            S_T6: begin w_ctrl.zlo_out = con_ff; w_ctrl.pc_in = con_ff; end
                            default: ;
                        endcase
                    end
                    CL_JR: if (r_state == S_T3) begin w_ctrl.gra = 1'b1; w_ctrl.r_out = 1'b1; w_ctrl.pc_in = 1'b1; end
                    CL_JAL: begin
                        case (r_state)
                            S_T3: begin w_ctrl.pc_out = 1'b1; w_ctrl.grb = 1'b1; w_ctrl.r_in = 1'b1; end
                            S_T4: begin w_ctrl.gra = 1'b1; w_ctrl.r_out = 1'b1; w_ctrl.pc_in = 1'b1; end
                            default: ;
                        endcase
                    end
                    CL_IN:   if (r_state == S_T3) begin w_ctrl.inport_out = 1'b1; w_ctrl.gra = 1'b1; w_ctrl.r_in = 1'b1; end
                    CL_OUT:  if (r_state == S_T3) begin w_ctrl.gra = 1'b1; w_ctrl.r_out = 1'b1; w_ctrl.outport_in = 1'b1; end
                    CL_MFHI: if (r_state == S_T3) begin w_ctrl.hi_out = 1'b1; w_ctrl.gra = 1'b1; w_ctrl.r_in = 1'b1; end
                    CL_MFLO: if (r_state == S_T3) begin w_ctrl.lo_out = 1'b1; w_ctrl.gra = 1'b1; w_ctrl.r_in = 1'b1; end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // clr kills every enable immediately so an aborted instruction cannot
    // write a register or memory on the way down.
    assign w_ctrl_gated = clr ? '0 : w_ctrl;

    assign PCout     = w_ctrl_gated.pc_out;
    assign Zlowout   = w_ctrl_gated.zlo_out;
    assign ZHighout  = w_ctrl_gated.zhi_out;
    assign MDRout    = w_ctrl_gated.mdr_out;
    assign HIout     = w_ctrl_gated.hi_out;
    assign LOout     = w_ctrl_gated.lo_out;
    assign InPortout = w_ctrl_gated.inport_out;
    assign Cout      = w_ctrl_gated.c_out;
    assign BAout     = w_ctrl_gated.ba_out;
    assign Rout      = w_ctrl_gated.r_out;
    assign MARin     = w_ctrl_gated.mar_in;
    assign PCin      = w_ctrl_gated.pc_in;
    assign MDRin     = w_ctrl_gated.mdr_in;
    assign IRin      = w_ctrl_gated.ir_in;
    assign Yin       = w_ctrl_gated.y_in;
    assign HIin      = w_ctrl_gated.hi_in;
    assign LOin      = w_ctrl_gated.lo_in;
    assign ZHIin     = w_ctrl_gated.zhi_in;
    assign ZLOin     = w_ctrl_gated.zlo_in;
    assign CONin     = w_ctrl_gated.con_in;
    assign OutPortin = w_ctrl_gated.outport_in;
    assign Rin       = w_ctrl_gated.r_in;
    assign Gra       = w_ctrl_gated.gra;
    assign Grb       = w_ctrl_gated.grb;
    assign Grc       = w_ctrl_gated.grc;
    assign IncPC     = w_ctrl_gated.inc_pc;
    assign Read      = w_ctrl_gated.read;
    assign Write     = w_ctrl_gated.write;

    // The ALU function is the opcode itself; the ALU only honours it while
    // Z is being loaded.
    assign alu_op = ir[31:27];
    assign run    = clr | (r_state != S_HALT);

    // Register fields of ir are consumed by the select/encode logic, not here.
    assign w_unused_ir = ^ir[26:0];

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: a step-counting model built from the
// instruction tables is compared every cycle, plus hand-computed spot checks.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] ir;
    logic        con_ff;
    logic PCout, Zlowout, ZHighout, MDRout, HIout, LOout, InPortout, Cout, BAout, Rout;
    logic MARin, PCin, MDRin, IRin, Yin, HIin, LOin, ZHIin, ZLOin, CONin, OutPortin, Rin;
    logic Gra, Grb, Grc, IncPC, Read, Write;
    logic [4:0] alu_op;
    logic run;

    control_unit dut (
        .clk(clk), .clr(clr), .ir(ir), .con_ff(con_ff),
        .PCout(PCout), .Zlowout(Zlowout), .ZHighout(ZHighout), .MDRout(MDRout),
        .HIout(HIout), .LOout(LOout), .InPortout(InPortout), .Cout(Cout),
        .BAout(BAout), .Rout(Rout), .MARin(MARin), .PCin(PCin), .MDRin(MDRin),
        .IRin(IRin), .Yin(Yin), .HIin(HIin), .LOin(LOin), .ZHIin(ZHIin),
        .ZLOin(ZLOin), .CONin(CONin), .OutPortin(OutPortin), .Rin(Rin),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .IncPC(IncPC), .Read(Read),
        .Write(Write), .alu_op(alu_op), .run(run)
    );

    always #5 clk = ~clk;

    localparam logic [27:0] B_PCOUT = 28'd1 << 0,  B_ZLOWOUT = 28'd1 << 1,  B_ZHIGHOUT = 28'd1 << 2;
    localparam logic [27:0] B_MDROUT = 28'd1 << 3, B_HIOUT = 28'd1 << 4,    B_LOOUT = 28'd1 << 5;
    localparam logic [27:0] B_INPORTOUT = 28'd1 << 6, B_COUT = 28'd1 << 7,  B_BAOUT = 28'd1 << 8;
    localparam logic [27:0] B_ROUT = 28'd1 << 9,   B_MARIN = 28'd1 << 10,   B_PCIN = 28'd1 << 11;
    localparam logic [27:0] B_MDRIN = 28'd1 << 12, B_IRIN = 28'd1 << 13,    B_YIN = 28'd1 << 14;
    localparam logic [27:0] B_HIIN = 28'd1 << 15,  B_LOIN = 28'd1 << 16,    B_ZHIIN = 28'd1 << 17;
    localparam logic [27:0] B_ZLOIN = 28'd1 << 18, B_CONIN = 28'd1 << 19,   B_OUTPORTIN = 28'd1 << 20;
    localparam logic [27:0] B_RIN = 28'd1 << 21,   B_GRA = 28'd1 << 22,     B_GRB = 28'd1 << 23;
    localparam logic [27:0] B_GRC = 28'd1 << 24,   B_INCPC = 28'd1 << 25,   B_READ = 28'd1 << 26;
    localparam logic [27:0] B_WRITE = 28'd1 << 27;

    localparam logic [27:0] F0 = B_PCOUT | B_MARIN | B_INCPC | B_ZLOIN;
    localparam logic [27:0] F1 = B_ZLOWOUT | B_PCIN | B_READ | B_MDRIN;
    localparam logic [27:0] F2 = B_MDROUT | B_IRIN;

    logic [27:0] dut_word;
    assign dut_word = {Write, Read, IncPC, Grc, Grb, Gra, Rin, OutPortin, CONin, ZLOin,
                       ZHIin, LOin, HIin, Yin, IRin, MDRin, PCin, MARin, Rout, BAout,
                       Cout, InPortout, LOout, HIout, MDRout, ZHighout, Zlowout, PCout};

    int n_checks = 0;
    int n_errors = 0;

    // Cycles per instruction including fetch, straight from the timing table.
    function automatic int seq_len(input logic [4:0] op);
        case (op)
            5'd20, 5'd22, 5'd23, 5'd24, 5'd25: return 4;
            5'd21, 5'd17, 5'd18:               return 5;
            5'd15, 5'd16, 5'd19:               return 7;
            5'd0, 5'd2:                        return 8;
            default: return ((op >= 5'd1 && op <= 5'd14) ? 6 : 3);
        endcase
    endfunction

    // Execute-step control words from the operation table.
    function automatic logic [27:0] exp_exec(input logic [4:0] op, input int st, input logic c);
        logic [27:0] w;
        w = '0;
        if (op >= 5'd3 && op <= 5'd14) begin
            if (st == 3) w = B_GRB | B_ROUT | B_YIN;
            if (st == 4) w = (op <= 5'd11) ? (B_GRC | B_ROUT | B_ZLOIN) : (B_COUT | B_ZLOIN);
            if (st == 5) w = B_ZLOWOUT | B_GRA | B_RIN;
        end else if (op == 5'd17 || op == 5'd18) begin
            if (st == 3) w = B_GRB | B_ROUT | B_ZLOIN;
            if (st == 4) w = B_ZLOWOUT | B_GRA | B_RIN;
        end else if (op == 5'd15 || op == 5'd16) begin
            if (st == 3) w = B_GRA | B_ROUT | B_YIN;
            if (st == 4) w = B_GRB | B_ROUT | B_ZHIIN | B_ZLOIN;
            if (st == 5) w = B_ZLOWOUT | B_LOIN;
            if (st == 6) w = B_ZHIGHOUT | B_HIIN;
        end else if (op <= 5'd2) begin
            if (st == 3) w = B_GRB | B_BAOUT | B_YIN;
            if (st == 4) w = B_COUT | B_ZLOIN;
            if (st == 5) w = (op == 5'd1) ? (B_ZLOWOUT | B_GRA | B_RIN) : (B_ZLOWOUT | B_MARIN);
            if (st == 6) w = (op == 5'd0) ? (B_READ | B_MDRIN) : (B_GRA | B_ROUT | B_MDRIN);
            if (st == 7) w = (op == 5'd0) ? (B_MDROUT | B_GRA | B_RIN) : B_WRITE;
        end else if (op == 5'd19) begin
            if (st == 3) w = B_GRA | B_ROUT | B_CONIN;
            if (st == 4) w = B_PCOUT | B_YIN;
            if (st == 5) w = B_COUT | B_ZLOIN;
            if (st == 6) w = c ? (B_ZLOWOUT | B_PCIN) : 28'd0;
        end else if (op == 5'd20) w = B_GRA | B_ROUT | B_PCIN;
        else if (op == 5'd21) w = (st == 3) ? (B_PCOUT | B_GRB | B_RIN) : (B_GRA | B_ROUT | B_PCIN);
        else if (op == 5'd22) w = B_INPORTOUT | B_GRA | B_RIN;
        else if (op == 5'd23) w = B_GRA | B_ROUT | B_OUTPORTIN;
        else if (op == 5'd24) w = B_HIOUT | B_GRA | B_RIN;
        else if (op == 5'd25) w = B_LOOUT | B_GRA | B_RIN;
        return w;
    endfunction

    // Model: phase (idle / running / halted), step within instruction, latched opcode.
    localparam logic [1:0] MP_IDLE = 2'd0, MP_RUN = 2'd1, MP_HALT = 2'd2;
    logic [1:0] m_phase = MP_IDLE;
    int         m_step  = 0;
    logic [4:0] m_op    = 5'd0;

    always @(posedge clk) begin
        if (clr) m_phase <= MP_IDLE;
        else begin
            case (m_phase)
                MP_IDLE: begin m_phase <= MP_RUN; m_step <= 0; end
                MP_RUN: begin
                    if (m_step == 2) begin
                        m_op <= ir[31:27];
                        if (ir[31:27] == 5'd27)            m_phase <= MP_HALT;
                        else if (seq_len(ir[31:27]) == 3)  m_step <= 0;
                        else                               m_step <= 3;
                    end else if (m_step == seq_len(m_op) - 1) m_step <= 0;
                    else m_step <= m_step + 1;
                end
                default: ;
            endcase
        end
    end

    logic [27:0] last_word;
    logic        last_run;
    logic [27:0] trace [8];
    logic [4:0]  trace_alu [8];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // One clock: compare DUT against the model at the falling edge, then
    // advance to just after the next rising edge.
    task automatic cycle();
        logic [27:0] ew;
        logic        er;
        @(negedge clk);
        if (clr)                    begin ew = '0; er = 1'b1; end
        else if (m_phase == MP_RUN) begin
            er = 1'b1;
            if (m_step == 0)      ew = F0;
            else if (m_step == 1) ew = F1;
            else if (m_step == 2) ew = F2;
            else                  ew = exp_exec(m_op, m_step, con_ff);
        end else begin ew = '0; er = (m_phase != MP_HALT); end
        last_word = dut_word;
        last_run  = run;
        n_checks++;
        if (dut_word !== ew || run !== er || alu_op !== ir[31:27]) begin
            n_errors++;
            $display("FAIL model_cmp t=%0t word=%h want=%h run=%b want=%b alu_op=%b want=%b",
                     $time, dut_word, ew, run, er, alu_op, ir[31:27]);
        end
        @(posedge clk);
        #2;
    endtask

    // Run one instruction from its T0 cycle for n cycles, then confirm T0 again.
    task automatic run_instr(input string name, input logic [31:0] iv, input logic c, input int n);
        ir = iv;
        con_ff = c;
        for (int k = 0; k < n; k++) begin
            cycle();
            trace[k] = last_word;
            trace_alu[k] = alu_op;
        end
        #1;
        chk({name, "_ret_T0"}, {4'd0, dut_word}, {4'd0, F0});
        $display("instr %s ir=%h con=%b cycles=%0d", name, iv, c, n);
    endtask

    logic [31:0] tbl_ir [14] = '{32'h0080_0010, 32'h0880_0005, 32'h5110_0000, 32'h6118_0003,
                                 32'h7918_0000, 32'h8910_0000, 32'h9110_0000, 32'hA100_0000,
                                 32'hB100_0000, 32'hB900_0000, 32'hC100_0000, 32'hC900_0000,
                                 32'hD000_0000, 32'hF000_0000};
    int tbl_n [14] = '{8, 6, 6, 6, 7, 5, 5, 4, 4, 4, 4, 4, 3, 3};

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int wc;
        logic rd;
        clr = 1'b1; ir = '0; con_ff = 1'b0;
        @(posedge clk); #2;
        for (int k = 0; k < 3; k++) cycle();
        chk("reset_word", {4'd0, last_word}, 32'd0);
        chk("reset_run", {31'd0, last_run}, 32'd1);
        clr = 1'b0;
        cycle();
        chk("idle_word", {4'd0, last_word}, 32'd0);

        // Abort mul at T4 with clr held for three cycles.
        ir = 32'h8118_0000;
        for (int k = 0; k < 4; k++) cycle();
        #1;
        chk("mul_T4", {4'd0, dut_word}, {4'd0, B_GRB | B_ROUT | B_ZHIIN | B_ZLOIN});
        clr = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("abort_word", {4'd0, last_word}, 32'd0);
            chk("abort_run", {31'd0, last_run}, 32'd1);
        end
        clr = 1'b0;
        cycle();
        #1;
        chk("release_T0", {4'd0, dut_word}, {4'd0, F0});

        run_instr("add", 32'h1A2B_8000, 1'b0, 6);
        chk("add_T0", {4'd0, trace[0]}, {4'd0, F0});
        chk("add_T1", {4'd0, trace[1]}, {4'd0, F1});
        chk("add_T2", {4'd0, trace[2]}, {4'd0, F2});
        chk("add_T3", {4'd0, trace[3]}, {4'd0, B_GRB | B_ROUT | B_YIN});
        chk("add_T4", {4'd0, trace[4]}, {4'd0, B_GRC | B_ROUT | B_ZLOIN});
        chk("add_T4_aluop", {27'd0, trace_alu[4]}, 32'd3);
        chk("add_T5", {4'd0, trace[5]}, {4'd0, B_ZLOWOUT | B_GRA | B_RIN});

        run_instr("br_nt", 32'h9980_0000, 1'b0, 7);
        chk("br_nt_T6", {4'd0, trace[6]}, 32'd0);
        run_instr("br_t", 32'h9980_0000, 1'b1, 7);
        chk("br_t_T6", {4'd0, trace[6]}, {4'd0, B_ZLOWOUT | B_PCIN});

        run_instr("jal", 32'hAC78_0000, 1'b0, 5);
        chk("jal_T3", {4'd0, trace[3]}, {4'd0, B_PCOUT | B_GRB | B_RIN});
        chk("jal_T4", {4'd0, trace[4]}, {4'd0, B_GRA | B_ROUT | B_PCIN});

        run_instr("st", 32'h1080_0057, 1'b0, 8);
        chk("st_T6", {4'd0, trace[6]}, {4'd0, B_GRA | B_ROUT | B_MDRIN});
        chk("st_T7", {4'd0, trace[7]}, {4'd0, B_WRITE});
        wc = 0; rd = 1'b0;
        for (int k = 0; k < 8; k++) wc += int'(trace[k][27]);
        for (int k = 3; k < 8; k++) rd |= trace[k][26];
        chk("st_write_once", wc, 32'd1);
        chk("st_no_read", {31'd0, rd}, 32'd0);

        for (int i = 0; i < 14; i++) run_instr($sformatf("op%0d", tbl_ir[i][31:27]), tbl_ir[i], 1'b0, tbl_n[i]);

        // halt: parks after T2 with everything low until clr.
        ir = 32'hD800_0000;
        for (int k = 0; k < 3; k++) cycle();
        for (int k = 0; k < 20; k++) begin
            cycle();
            chk("halt_word", {4'd0, last_word}, 32'd0);
            chk("halt_run", {31'd0, last_run}, 32'd0);
        end
        $display("instr halt ir=%h held=20", ir);
        clr = 1'b1;
        cycle();
        chk("halt_clr_run", {31'd0, last_run}, 32'd1);
        clr = 1'b0;
        cycle();
        chk("halt_idle_run", {31'd0, last_run}, 32'd1);
        #1;
        chk("halt_restart_T0", {4'd0, dut_word}, {4'd0, F0});

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
